// File: rtl/pcm_pkg.sv
// Shared types and constants for the serial PCM receive path.
package pcm_pkg;

    localparam int unsigned PCM_SLOT_W       = 32;
    localparam int unsigned PCM_SYNC_DEFAULT = 2;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } pcm_rx_state_t;

endpackage

// File: rtl/pcm_i2s_rx_if.sv
// Serial link inputs and parallel PCM outputs of the I2S receiver.
interface pcm_i2s_rx_if
    import pcm_pkg::*;
#(
    parameter int unsigned SLOT_W = PCM_SLOT_W
) ();

    logic              bick;
    logic              lrck;
    logic              sdata;
    logic [SLOT_W-1:0] pcm_ldata;
    logic [SLOT_W-1:0] pcm_rdata;
    logic              pcm_valid;
    logic              frame_err;
    logic              locked;

    modport master (
        output bick, lrck, sdata,
        input  pcm_ldata, pcm_rdata, pcm_valid, frame_err, locked
    );

    modport slave (
        input  bick, lrck, sdata,
        output pcm_ldata, pcm_rdata, pcm_valid, frame_err, locked
    );

endinterface

// File: rtl/pcm_sync_edge.sv
// N-stage synchroniser plus one delay flop; registered level and edge outputs
// all share the same latency so data and strobes stay aligned.
module pcm_sync_edge
    import pcm_pkg::*;
#(
    parameter int unsigned STAGES = PCM_SYNC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        dly_d  = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~dly_q;
        fall_d = ~sync_q[STAGES-1] & dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sync_o = dly_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/pcm_i2s_rx.sv
// I2S receiver: oversamples bick/lrck/sdata in the mclk domain, checks slot
// framing and emits each complete stereo pair with a one-cycle strobe.
module pcm_i2s_rx
    import pcm_pkg::*;
#(
    parameter int unsigned SLOT_W      = PCM_SLOT_W,
    parameter int unsigned SYNC_STAGES = PCM_SYNC_DEFAULT
) (
    input  logic         mclk,
    input  logic         reset,
    pcm_i2s_rx_if.slave  rx
);

    localparam int unsigned CNT_W = $clog2(SLOT_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(SLOT_W + 1);

    logic brise, bick_s, bick_fall;
    logic lrck_s, lrck_rise, lrck_fall;
    logic sdata_s, sdata_rise, sdata_fall;
    logic unused_edges;

    pcm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bick (
        .clk(mclk), .reset(reset), .din(rx.bick),
        .sync_o(bick_s), .rise_o(brise), .fall_o(bick_fall)
    );
    pcm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(mclk), .reset(reset), .din(rx.lrck),
        .sync_o(lrck_s), .rise_o(lrck_rise), .fall_o(lrck_fall)
    );
    pcm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(mclk), .reset(reset), .din(rx.sdata),
        .sync_o(sdata_s), .rise_o(sdata_rise), .fall_o(sdata_fall)
    );

    assign unused_edges = ^{bick_s, bick_fall, lrck_rise, lrck_fall, sdata_rise, sdata_fall};

    pcm_rx_state_t     state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [SLOT_W-1:0] shreg_q, shreg_d;
    logic [SLOT_W-1:0] left_pend_q, left_pend_d;
    logic              lrck_prev_q, lrck_prev_d;
    logic [SLOT_W-1:0] pcm_ldata_q, pcm_ldata_d;
    logic [SLOT_W-1:0] pcm_rdata_q, pcm_rdata_d;
    logic              pcm_valid_q, pcm_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              locked_q, locked_d;

    logic [SLOT_W-1:0] shift_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              bound_c, fall_bound_c, dir_ok_c;

    // Framing: count bits per slot, accept only SLOT_W-bit slots in L/R order
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        left_pend_d = left_pend_q;
        lrck_prev_d = lrck_prev_q;
        pcm_ldata_d = pcm_ldata_q;
        pcm_rdata_d = pcm_rdata_q;
        pcm_valid_d = 1'b0;
        frame_err_d = 1'b0;
        locked_d    = locked_q;

        shift_c      = {shreg_q[SLOT_W-2:0], sdata_s};
        cnt_inc_c    = (bitcnt_q == CNT_OVER) ? CNT_OVER : bitcnt_q + CNT_W'(1);
        bound_c      = lrck_s != lrck_prev_q;
        fall_bound_c = bound_c & ~lrck_s;
        dir_ok_c     = lrck_s == (state_q == LEFT);

        if (brise) begin
            shreg_d     = shift_c;
            lrck_prev_d = lrck_s;
            unique case (state_q)
                HUNT: begin
                    bitcnt_d = '0;
                    if (fall_bound_c) state_d = LEFT;
                end
                LEFT, RIGHT: begin
                    bitcnt_d = cnt_inc_c;
                    if (bound_c) begin
                        bitcnt_d = '0;
                        if (cnt_inc_c == CNT_FULL && dir_ok_c) begin
                            if (state_q == LEFT) begin
                                left_pend_d = shift_c;
                                state_d     = RIGHT;
                            end else begin
                                pcm_ldata_d = left_pend_q;
                                pcm_rdata_d = shift_c;
                                pcm_valid_d = 1'b1;
                                locked_d    = 1'b1;
                                state_d     = LEFT;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            locked_d    = 1'b0;
                            state_d     = fall_bound_c ? LEFT : HUNT;
                        end
                    end else if (cnt_inc_c == CNT_OVER) begin
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        bitcnt_d    = '0;
                        state_d     = HUNT;
                    end
                end
                default: begin
                    bitcnt_d = '0;
                    state_d  = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q     <= HUNT;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            left_pend_q <= '0;
            lrck_prev_q <= 1'b0;
            pcm_ldata_q <= '0;
            pcm_rdata_q <= '0;
            pcm_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            left_pend_q <= left_pend_d;
            lrck_prev_q <= lrck_prev_d;
            pcm_ldata_q <= pcm_ldata_d;
            pcm_rdata_q <= pcm_rdata_d;
            pcm_valid_q <= pcm_valid_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
        end
    end

    assign rx.pcm_ldata = pcm_ldata_q;
    assign rx.pcm_rdata = pcm_rdata_q;
    assign rx.pcm_valid = pcm_valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.locked    = locked_q;

endmodule

// File: tb/tb_pcm_i2s_rx.sv
// Bench for pcm_i2s_rx: drives I2S frames into a default-depth and a 3-stage
// receiver and checks both every cycle against a slot-level framing model.
module tb_pcm_i2s_rx;
    import pcm_pkg::*;

    localparam int unsigned W = PCM_SLOT_W;
    localparam int M_HUNT  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;

    logic mclk = 1'b0;
    logic reset, bick, lrck, sdata;
    int   cyc = 0;
    int   skew = 5;
    bit   started = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        int          n;
        bit          is_err;
        logic [31:0] l;
        logic [31:0] r;
    } ev_t;

    ev_t         evq[$];
    int          rd[2];
    logic [31:0] exp_l[2];
    logic [31:0] exp_r[2];
    bit          exp_lk[2];
    int          cnt_v[2];
    int          cnt_e[2];

    int          m_state;
    bit          m_lr_prev;
    int          rise_idx;
    int          last_bnd;
    logic [31:0] m_pend;
    logic        carry;
    logic [31:0] prev_val;

    pcm_i2s_rx_if #(.SLOT_W(W)) if2 ();
    pcm_i2s_rx_if #(.SLOT_W(W)) if3 ();

    assign if2.bick = bick;  assign if2.lrck = lrck;  assign if2.sdata = sdata;
    assign if3.bick = bick;  assign if3.lrck = lrck;  assign if3.sdata = sdata;

    pcm_i2s_rx #(.SLOT_W(W), .SYNC_STAGES(2)) dut2 (.mclk(mclk), .reset(reset), .rx(if2.slave));
    pcm_i2s_rx #(.SLOT_W(W), .SYNC_STAGES(3)) dut3 (.mclk(mclk), .reset(reset), .rx(if3.slave));

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", name, i, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state   = M_HUNT;
        m_lr_prev = 1'b0;
        rise_idx  = 0;
        last_bnd  = 0;
        m_pend    = '0;
        for (int i = 0; i < 2; i++) begin
            rd[i]     = evq.size();
            exp_l[i]  = '0;
            exp_r[i]  = '0;
            exp_lk[i] = 1'b0;
        end
    endtask

    task automatic push_ev(input int n, input bit is_err, input logic [31:0] l, input logic [31:0] r);
        ev_t e;
        e.n = n; e.is_err = is_err; e.l = l; e.r = r;
        evq.push_back(e);
    endtask

    // Slot rules: a slot is the run of bick rises between lrck boundaries; it
    // must be exactly W rises long and alternate left then right.
    task automatic model_rise(input logic lr, input logic [31:0] ended_val, input int n);
        int len;
        bit bnd;
        rise_idx++;
        len = rise_idx - last_bnd;
        bnd = (lr != m_lr_prev);
        m_lr_prev = lr;
        if (m_state == M_HUNT) begin
            if (bnd && !lr) begin
                m_state  = M_LEFT;
                last_bnd = rise_idx;
            end
        end else if (bnd) begin
            if (len == int'(W) && lr == (m_state == M_LEFT)) begin
                if (m_state == M_LEFT) begin
                    m_pend  = ended_val;
                    m_state = M_RIGHT;
                end else begin
                    push_ev(n, 1'b0, m_pend, ended_val);
                    m_state = M_LEFT;
                end
            end else begin
                push_ev(n, 1'b1, '0, '0);
                m_state = lr ? M_HUNT : M_LEFT;
            end
            last_bnd = rise_idx;
        end else if (len == int'(W) + 1) begin
            push_ev(n, 1'b1, '0, '0);
            m_state = M_HUNT;
        end
    endtask

    task automatic check_dut(input int i, input int s, input logic v, input logic e, input logic lk,
                             input logic [31:0] l, input logic [31:0] r);
        bit ev_v, ev_e;
        ev_v = 1'b0;
        ev_e = 1'b0;
        if (rd[i] < evq.size()) begin
            if (evq[rd[i]].n + s + 1 == cyc) begin
                if (evq[rd[i]].is_err) begin
                    ev_e      = 1'b1;
                    exp_lk[i] = 1'b0;
                end else begin
                    ev_v      = 1'b1;
                    exp_lk[i] = 1'b1;
                    exp_l[i]  = evq[rd[i]].l;
                    exp_r[i]  = evq[rd[i]].r;
                end
                rd[i]++;
            end
        end
        if (v === 1'b1) cnt_v[i]++;
        if (e === 1'b1) cnt_e[i]++;
        chk("pcm_valid", i, 32'(v), 32'(ev_v));
        chk("frame_err", i, 32'(e), 32'(ev_e));
        chk("locked", i, 32'(lk), 32'(exp_lk[i]));
        chk("pcm_ldata", i, l, exp_l[i]);
        chk("pcm_rdata", i, r, exp_r[i]);
    endtask

    always @(posedge mclk) begin
        #2;
        if (started) begin
            check_dut(0, 2, if2.pcm_valid, if2.frame_err, if2.locked, if2.pcm_ldata, if2.pcm_rdata);
            check_dut(1, 3, if3.pcm_valid, if3.frame_err, if3.locked, if3.pcm_ldata, if3.pcm_rdata);
        end
    end

    // One bick period: fall (lrck/sdata change) then rise, 4 mclk each phase
    task automatic send_bit(input logic lr, input logic b, input bit do_rst, input logic [31:0] ended_val);
        @(posedge mclk); #(skew);
        bick = 1'b0; lrck = lr; sdata = b;
        if (do_rst) begin
            @(posedge mclk); #(skew); reset = 1'b1;
            @(posedge mclk); model_reset(); #(skew); reset = 1'b0;
            repeat (2) @(posedge mclk);
        end else begin
            repeat (4) @(posedge mclk);
        end
        #(skew); bick = 1'b1;
        model_rise(lr, ended_val, cyc + 1);
        repeat (3) @(posedge mclk);
    endtask

    task automatic send_slot(input logic lr, input int len, input logic [63:0] val, input int rst_k);
        for (int k = 0; k < len; k++) begin
            logic b;
            b = (k == 0) ? carry : val[len - k];
            send_bit(lr, b, k == rst_k, prev_val);
        end
        carry    = val[0];
        prev_val = val[31:0];
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r);
        send_slot(1'b0, 32, {32'h0, l}, -1);
        send_slot(1'b1, 32, {32'h0, r}, -1);
    endtask

    task automatic chk_counts(input string name, input int v, input int e);
        for (int i = 0; i < 2; i++) begin
            chk({name, "_valids"}, i, 32'(cnt_v[i]), 32'(v));
            chk({name, "_errs"}, i, 32'(cnt_e[i]), 32'(e));
        end
    endtask

    initial begin
        reset = 1'b1; bick = 1'b0; lrck = 1'b0; sdata = 1'b0;
        carry = 1'b0; prev_val = '0;
        for (int i = 0; i < 2; i++) begin cnt_v[i] = 0; cnt_e[i] = 0; end
        model_reset();
        @(posedge mclk);
        started = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        reset = 1'b0;
        chk("rst_ldata", 0, if2.pcm_ldata, 32'h0);
        chk("rst_rdata", 0, if2.pcm_rdata, 32'h0);
        chk("rst_valid", 0, 32'(if2.pcm_valid), 32'h0);
        chk("rst_err", 0, 32'(if2.frame_err), 32'h0);
        chk("rst_locked", 1, 32'(if3.locked), 32'h0);

        // Steady frames after one hunt frame
        skew = 5;
        repeat (3) frame(32'h12345678, 32'h9ABCDEF0);
        chk("p1_ldata", 0, if2.pcm_ldata, 32'h12345678);
        chk("p1_rdata", 0, if2.pcm_rdata, 32'h9ABCDEF0);
        chk("p1_locked", 0, 32'(if2.locked), 32'h1);
        chk_counts("p1", 1, 0);

        // Extreme values, alternating
        skew = 1;
        frame(32'h80000000, 32'h7FFFFFFF);
        frame(32'hFFFFFFFF, 32'h00000001);
        frame(32'h80000000, 32'h7FFFFFFF);
        frame(32'hFFFFFFFF, 32'h00000001);
        chk("p2_ldata", 1, if3.pcm_ldata, 32'h80000000);
        chk("p2_rdata", 1, if3.pcm_rdata, 32'h7FFFFFFF);
        chk_counts("p2", 5, 0);

        // Short left slot
        skew = 9;
        send_slot(1'b0, 31, 64'h0BADF00D, -1);
        send_slot(1'b1, 32, 64'h55555555, -1);
        chk("p3_unlocked", 0, 32'(if2.locked), 32'h0);
        chk("p3_hold_l", 0, if2.pcm_ldata, 32'hFFFFFFFF);
        frame(32'h12345678, 32'h9ABCDEF0);
        frame(32'h12345678, 32'h9ABCDEF0);
        chk("p3_relocked", 0, 32'(if2.locked), 32'h1);
        chk_counts("p3", 7, 1);

        // Overlong right slots: 33 data bits, then boundary at count 33
        skew = 3;
        send_slot(1'b0, 32, 64'h12345678, -1);
        send_slot(1'b1, 34, 64'h3_CAFEBABE, -1);
        frame(32'h12345678, 32'h9ABCDEF0);
        chk("p4_hold_l", 0, if2.pcm_ldata, 32'h12345678);
        chk("p4_hold_r", 0, if2.pcm_rdata, 32'h9ABCDEF0);
        chk("p4_unlocked", 0, 32'(if2.locked), 32'h0);
        chk_counts("p4a", 8, 2);
        frame(32'h12345678, 32'h9ABCDEF0);
        send_slot(1'b0, 32, 64'h12345678, -1);
        send_slot(1'b1, 33, 64'h1_DEADBEEF, -1);
        frame(32'h12345678, 32'h9ABCDEF0);
        chk_counts("p4b", 10, 3);

        // Reset in the middle of a right slot
        skew = 7;
        send_slot(1'b0, 32, 64'h12345678, -1);
        send_slot(1'b1, 32, 64'h9ABCDEF0, 10);
        chk("p5_rst_l", 0, if2.pcm_ldata, 32'h0);
        chk("p5_rst_r", 1, if3.pcm_rdata, 32'h0);
        chk("p5_rst_lk", 0, 32'(if2.locked), 32'h0);
        frame(32'h12345678, 32'h9ABCDEF0);
        chk_counts("p5a", 11, 3);
        frame(32'h12345678, 32'h9ABCDEF0);
        send_slot(1'b0, 32, 64'h12345678, -1);
        repeat (10) @(posedge mclk);
        #1;
        chk("end_ldata", 0, if2.pcm_ldata, 32'h12345678);
        chk("end_rdata", 1, if3.pcm_rdata, 32'h9ABCDEF0);
        chk("end_locked", 1, 32'(if3.locked), 32'h1);
        chk_counts("end", 13, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcm_i2s_rx.md
# pcm_i2s_rx

Serial PCM receiver that sits at the far end of the on-board audio link driven by the sine/PCM generator path. It oversamples the incoming bit clock, word clock and serial data in the `mclk` domain, deserialises I2S-format 32-bit slots, and presents each stereo pair as two parallel 32-bit words with a one-cycle valid strobe. Framing is checked continuously: a bad slot length raises an error pulse and forces resynchronisation.

## Interface
- `SLOT_W`, default 32, bits per channel slot and width of the output words.
- `SYNC_STAGES`, default 2, synchroniser depth for `bick`, `lrck` and `sdata`; minimum 2.
- `mclk`  in  1  master clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `bick`  in  1  serial bit clock, asynchronous to `mclk`. High and low phases are each at least 2 `mclk` periods; the nominal rate is `mclk`/8.
- `lrck`  in  1  word clock: 0 selects the left slot, 1 the right slot. It changes on the `bick` falling edge.
- `sdata`  in  1  serial data, MSB first, one-bit I2S delay after each `lrck` edge.
- `pcm_ldata`  out  SLOT_W  last complete left sample, two's complement.
- `pcm_rdata`  out  SLOT_W  last complete right sample, two's complement.
- `pcm_valid`  out  1  one-cycle pulse; new `pcm_ldata`/`pcm_rdata` pair.
- `frame_err`  out  1  one-cycle pulse; slot length violation.
- `locked`  out  1  high after a complete error-free stereo frame.

## Operation
- All three serial inputs pass through `SYNC_STAGES` flops, then one extra flop for edge detection. `brise` = synchronised `bick` rising edge.
- On every `brise`:
  - shift synchronised `sdata` into `shreg[SLOT_W-1:0]` at bit 0;
  - compare synchronised `lrck` with `lrck_prev`, which is updated only on `brise`. A mismatch is a slot boundary. The bit shifted at the boundary is the LSB of the slot just ended.
- `bitcnt` counts bits shifted in the current slot, including the boundary bit. It saturates at SLOT_W+1.
- States:
  - HUNT: shifting is ignored. A 1→0 boundary moves to LEFT with `bitcnt`=0; the boundary bit belongs to the previous frame and is discarded.
  - LEFT: a 0→1 boundary with `bitcnt`==SLOT_W latches `left_pend`={shreg after shift} and moves to RIGHT with `bitcnt`=0.
  - RIGHT: a 1→0 boundary with `bitcnt`==SLOT_W updates `pcm_ldata`←`left_pend` and `pcm_rdata`←{shreg after shift}, pulses `pcm_valid`, sets `locked`, and moves to LEFT with `bitcnt`=0.
- Error conditions, in LEFT or RIGHT:
  - a boundary with `bitcnt`≠SLOT_W;
  - `bitcnt` reaching SLOT_W+1 with no boundary.
- On any error: pulse `frame_err`, clear `locked`, no `pcm_valid`, outputs hold their previous values.
  - If the erroring edge is a 1→0 boundary, go directly to LEFT with `bitcnt`=0.
  - Otherwise go to HUNT.
- A boundary in the wrong direction for the current state (e.g. a 1→0 boundary while in LEFT) is an error.
- Output words are never partially updated. Left and right always change on the same cycle.

## Timing
- Reset values: `pcm_ldata`=0, `pcm_rdata`=0, `pcm_valid`=0, `frame_err`=0, `locked`=0. State=HUNT; `bitcnt`, `shreg`, `left_pend`, `lrck_prev` and all synchroniser flops are 0.
- `reset` sampled high at a `mclk` edge takes effect at that edge, including mid-slot. An in-progress word is discarded.
- Latency: if the `bick` rising edge that carries the right LSB is first sampled high at `mclk` edge n, then `pcm_valid` and the new data are registered at edge n+SYNC_STAGES+1. With the default depth this is edge n+3.
- `frame_err` has the same latency relative to the offending `bick` edge.
- `pcm_valid` and `frame_err` are never high in the same cycle, and each is high for exactly one cycle.
- Throughput: one pair per frame. 64 `bick` periods per frame at SLOT_W=32.

## Structure
- Shared package `pcm_pkg`:
  - `PCM_SLOT_W`=32;
  - `pcm_rx_state_t` enum {HUNT, LEFT, RIGHT};
  - `PCM_SYNC_DEFAULT`=2.
- Sub-module `pcm_sync_edge`: a parameterised N-stage synchroniser with registered rising/falling edge outputs. It is instantiated for `bick`, and used as plain synchroniser for `lrck` and `sdata` so all three see equal delay.

## Test plan
- Reset, then serialise frames of L=0x12345678 and R=0x9ABCDEF0 with `bick`=`mclk`/8. After the first hunt frame, each frame gives one `pcm_valid` with exactly those values, and `locked`=1.
- Alternating frames L=0x80000000/R=0x7FFFFFFF and L=0xFFFFFFFF/R=0x00000001 → one `pcm_valid` per frame, values exact, no `frame_err`.
- Left slot with 31 bits → `frame_err` pulse at the 0→1 boundary, no `pcm_valid`, `locked`=0. The block relocks and `pcm_valid` returns on the next complete good frame.
- Right slot with 33 bits → `frame_err` on the 33rd `brise`, state HUNT, outputs unchanged.
- Assert `reset` for one cycle mid-right-slot → all outputs 0 next cycle. The partial frame produces no `pcm_valid`; the first valid follows the next full left+right frame after a 1→0 boundary.
- Latency check with SYNC_STAGES=3 → `pcm_valid` at exactly edge n+4 after right-LSB `bick` capture, repeated with `bick` phase skewed relative to `mclk`.
